// File: rtl/fb_pkg.sv
// Shared constants and types for the AHB-Lite VGA frame buffer.
package fb_pkg;

   localparam int          FB_W           = 640;
   localparam int          FB_H           = 480;
   localparam int          WORDS_PER_LINE = FB_W / 32;
   localparam int          FB_WORDS       = WORDS_PER_LINE * FB_H;
   localparam logic [13:0] CTRL_WADDR     = 14'h3FFC;
   localparam logic [2:0]  HSIZE_WORD     = 3'b010;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_t;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port frame RAM: port A read/write, port B read-only, both with registered reads.
module fb_dpram #(
   parameter int DEPTH = 9600,
   parameter int AW    = 14
) (
   input  logic          clk_i,
   input  logic          weA_i,
   input  logic [AW-1:0] addrA_i,
   input  logic [31:0]   wdataA_i,
   output logic [31:0]   rdataA_o,
   input  logic [AW-1:0] addrB_i,
   output logic [31:0]   rdataB_o
);

   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] rdataA_q;
   logic [31:0] rdataB_q;

   // No reset on the read registers so the block maps onto M10K.
   always_ff @(posedge clk_i) begin
      if (weA_i) begin
         mem[addrA_i] <= wdataA_i;
      end
      rdataA_q <= mem[addrA_i];
   end

   always_ff @(posedge clk_i) begin
      rdataB_q <= mem[addrB_i];
   end

   assign rdataA_o = rdataA_q;
   assign rdataB_o = rdataB_q;

endmodule

// File: rtl/ahb_vga_framebuffer.sv
// AHB-Lite slave holding a 1bpp frame buffer, with a hardware clear engine and a
// two-cycle pixel lookup port for the VGA scan generator.
module ahb_vga_framebuffer
   import fb_pkg::*;
#(
   parameter int H_PIXELS = FB_W,
   parameter int V_PIXELS = FB_H
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [15:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   input  logic [9:0]  pixel_x,
   input  logic [8:0]  pixel_y,
   output logic        pixel
);

   localparam logic [13:0] WPL_W     = 14'(H_PIXELS / 32);
   localparam logic [13:0] NUM_WORDS = 14'((H_PIXELS / 32) * V_PIXELS);
   localparam logic [13:0] LAST_WORD = NUM_WORDS - 14'd1;
   localparam logic [9:0]  X_MAX     = 10'(H_PIXELS - 1);
   localparam logic [8:0]  Y_MAX     = 9'(V_PIXELS - 1);

   clr_state_t  state_q, state_d;
   logic [13:0] cnt_q, cnt_d;
   logic        clrVal_q, clrVal_d;
   logic        dpValid_q, dpValid_d;
   logic        dpWrite_q, dpWrite_d;
   logic [2:0]  dpSize_q, dpSize_d;
   logic [13:0] dpAddr_q, dpAddr_d;
   logic        rdDone_q, rdDone_d;
   logic        pixInRange_q;
   logic [4:0]  bitSel_q;
   logic        pixel_q;

   logic        busy;
   logic        dpWord, dpFrame, dpCtrl;
   logic        readyOut;
   logic [31:0] rdData;
   logic        ramWe;
   logic [13:0] ramAddrA;
   logic [31:0] ramWdata;
   logic [31:0] ramRdataA;
   logic [31:0] ramRdataB;
   logic [9:0]  xClamp;
   logic [8:0]  yClamp;
   logic        pixInRange;
   logic [13:0] pixAddr;
   logic        unusedBits;

   assign unusedBits = ^{HADDR[1:0], HTRANS[0]};

   assign busy    = (state_q == CLEAR);
   assign dpWord  = dpValid_q && (dpSize_q == HSIZE_WORD);
   assign dpFrame = dpWord && (dpAddr_q < NUM_WORDS);
   assign dpCtrl  = dpWord && (dpAddr_q == CTRL_WADDR);

   // The clear engine owns port A; frame accesses stall until it returns to IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clrVal_d  = clrVal_q;
      dpValid_d = dpValid_q;
      dpWrite_d = dpWrite_q;
      dpSize_d  = dpSize_q;
      dpAddr_d  = dpAddr_q;
      readyOut  = 1'b1;
      rdData    = 32'd0;
      ramWe     = 1'b0;
      ramAddrA  = dpAddr_q;
      ramWdata  = HWDATA;

      if (HREADY) begin
         dpValid_d = HSEL && HTRANS[1];
         dpWrite_d = HWRITE;
         dpSize_d  = HSIZE;
         dpAddr_d  = HADDR[15:2];
      end

      if (dpFrame) begin
         if (busy) begin
            readyOut = 1'b0;
         end else if (dpWrite_q) begin
            ramWe = 1'b1;
         end else if (!rdDone_q) begin
            readyOut = 1'b0;
         end else begin
            rdData = ramRdataA;
         end
      end
      rdDone_d = dpFrame && !dpWrite_q && !busy && !rdDone_q;

      if (dpCtrl && !dpWrite_q) begin
         rdData = {30'd0, clrVal_q, busy};
      end

      case (state_q)
         IDLE: begin
            if (dpCtrl && dpWrite_q && HWDATA[1]) begin
               state_d  = CLEAR;
               cnt_d    = 14'd0;
               clrVal_d = HWDATA[0];
            end
         end
         CLEAR: begin
            ramWe    = 1'b1;
            ramAddrA = cnt_q;
            ramWdata = {32{clrVal_q}};
            cnt_d    = cnt_q + 14'd1;
            if (cnt_q == LAST_WORD) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         cnt_q     <= 14'd0;
         clrVal_q  <= 1'b0;
         dpValid_q <= 1'b0;
         dpWrite_q <= 1'b0;
         dpSize_q  <= 3'd0;
         dpAddr_q  <= 14'd0;
         rdDone_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clrVal_q  <= clrVal_d;
         dpValid_q <= dpValid_d;
         dpWrite_q <= dpWrite_d;
         dpSize_q  <= dpSize_d;
         dpAddr_q  <= dpAddr_d;
         rdDone_q  <= rdDone_d;
      end
   end

   // Off-screen coordinates still issue a clamped RAM read; the result is masked.
   assign xClamp     = (pixel_x > X_MAX) ? X_MAX : pixel_x;
   assign yClamp     = (pixel_y > Y_MAX) ? Y_MAX : pixel_y;
   assign pixInRange = (pixel_x <= X_MAX) && (pixel_y <= Y_MAX);
   assign pixAddr    = 14'(yClamp) * WPL_W + 14'(xClamp[9:5]);

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pixInRange_q <= 1'b0;
         bitSel_q     <= 5'd0;
         pixel_q      <= 1'b0;
      end else begin
         pixInRange_q <= pixInRange;
         bitSel_q     <= pixel_x[4:0];
         pixel_q      <= pixInRange_q & ramRdataB[bitSel_q];
      end
   end

   fb_dpram #(
      .DEPTH (FB_WORDS),
      .AW    (14)
   ) uRam (
      .clk_i    (HCLK),
      .weA_i    (ramWe),
      .addrA_i  (ramAddrA),
      .wdataA_i (ramWdata),
      .rdataA_o (ramRdataA),
      .addrB_i  (pixAddr),
      .rdataB_o (ramRdataB)
   );

   assign HRDATA    = rdData;
   assign HREADYOUT = readyOut;
   assign HRESP     = 1'b0;
   assign pixel     = pixel_q;

endmodule

// File: tb/tb_ahb_vga_framebuffer.sv
// Self-checking bench for ahb_vga_framebuffer: AHB transfers plus a pixel scoreboard.
module tb_ahb_vga_framebuffer;

   localparam int TIMEOUT = 20000;

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL    = 1'b0;
   logic [15:0] HADDR   = 16'd0;
   logic [1:0]  HTRANS  = 2'b00;
   logic        HWRITE  = 1'b0;
   logic [2:0]  HSIZE   = 3'b010;
   logic        HREADY;
   logic [31:0] HWDATA  = 32'd0;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [9:0]  pixel_x = 10'd0;
   logic [8:0]  pixel_y = 9'd0;
   logic        pixel;

   int checkCount = 0;
   int passCount  = 0;
   int cycleCnt   = 0;

   typedef struct {
      int   group;
      int   x;
      int   y;
      logic exp;
   } pixVec_t;

   typedef struct {
      int   due;
      logic exp;
      int   x;
      int   y;
   } pixExp_t;

   pixVec_t vecs[$];
   pixExp_t sbQueue[$];

   assign HREADY = HREADYOUT;

   always #10 HCLK = ~HCLK;

   always @(posedge HCLK) cycleCnt <= cycleCnt + 1;

   ahb_vga_framebuffer dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .pixel     (pixel)
   );

   function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endfunction

   // Pixel scoreboard: each entry is due two cycles after its coordinate was presented.
   always @(negedge HCLK) begin
      pixExp_t e;
      while (sbQueue.size() > 0 && sbQueue[0].due <= cycleCnt) begin
         e = sbQueue.pop_front();
         checkOutput($sformatf("pixel(%0d,%0d)", e.x, e.y), {31'd0, pixel}, {31'd0, e.exp});
      end
   end

   task automatic applyStimulus(input int group);
      pixVec_t v;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.group == group) begin
            @(negedge HCLK);
            pixel_x = 10'(v.x);
            pixel_y = 9'(v.y);
            sbQueue.push_back('{cycleCnt + 2, v.exp, v.x, v.y});
         end
      end
      repeat (3) @(negedge HCLK);
   endtask

   task automatic waitReady(input string name, output int waits);
      waits = 0;
      while (!HREADYOUT && waits < TIMEOUT) begin
         @(posedge HCLK);
         @(negedge HCLK);
         waits++;
      end
      if (!HREADYOUT) begin
         checkCount++;
         $display("[TB] FAIL %s: HREADYOUT still low after %0d cycles, required high", name, waits);
      end
   endtask

   task automatic ahbXfer(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int waits);
      @(negedge HCLK);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HADDR  = addr;
      HSIZE  = size;
      @(posedge HCLK);
      @(negedge HCLK);
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HWDATA = wdata;
      waitReady($sformatf("xfer 0x%04h", addr), waits);
      rdata = HRDATA;
      @(posedge HCLK);
   endtask

   task automatic ahbWrite(input logic [15:0] addr, input logic [31:0] data, output int waits);
      logic [31:0] dummy;
      ahbXfer(1'b1, addr, 3'b010, data, dummy, waits);
   endtask

   task automatic ahbRead(input logic [15:0] addr, output logic [31:0] data, output int waits);
      ahbXfer(1'b0, addr, 3'b010, 32'd0, data, waits);
   endtask

   // Read addressed during the data phase of a write to the same word.
   task automatic ahbWriteThenRead(input logic [15:0] addr, input logic [31:0] data,
                                   output logic [31:0] rdata, output int waits);
      @(negedge HCLK);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = addr;
      HSIZE  = 3'b010;
      @(posedge HCLK);
      @(negedge HCLK);
      HWRITE = 1'b0;
      HWDATA = data;
      @(posedge HCLK);
      @(negedge HCLK);
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      waitReady("write-then-read", waits);
      rdata = HRDATA;
      @(posedge HCLK);
   endtask

   initial begin
      logic [31:0] rd;
      int          w;

      vecs.push_back('{1, 0, 0, 1'b1});
      vecs.push_back('{1, 1, 0, 1'b0});
      vecs.push_back('{1, 31, 1, 1'b1});
      vecs.push_back('{1, 32, 1, 1'b0});
      vecs.push_back('{1, 3, 5, 1'b1});
      vecs.push_back('{1, 0, 5, 1'b0});
      vecs.push_back('{1, 700, 10, 1'b0});
      vecs.push_back('{1, 10, 500, 1'b0});
      vecs.push_back('{2, 0, 0, 1'b1});
      vecs.push_back('{2, 1, 0, 1'b0});
      vecs.push_back('{2, 31, 0, 1'b0});
      vecs.push_back('{3, 0, 0, 1'b0});
      vecs.push_back('{3, 32, 0, 1'b1});
      vecs.push_back('{3, 639, 479, 1'b1});
      vecs.push_back('{3, 320, 240, 1'b1});
      vecs.push_back('{3, 1, 0, 1'b0});
      vecs.push_back('{3, 700, 10, 1'b0});
      vecs.push_back('{3, 10, 500, 1'b0});
      vecs.push_back('{4, 639, 479, 1'b1});
      vecs.push_back('{4, 600, 400, 1'b1});
      vecs.push_back('{4, 0, 0, 1'b0});

      $display("[TB] reset");
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      checkOutput("reset HRDATA", HRDATA, 32'd0);
      checkOutput("reset HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
      checkOutput("reset HRESP", {31'd0, HRESP}, 32'd0);
      checkOutput("reset pixel", {31'd0, pixel}, 32'd0);
      HRESETn = 1'b1;

      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl after reset", rd, 32'd0);
      checkOutput("ctrl read waits", w, 32'd0);

      $display("[TB] clear to 0");
      ahbWrite(16'hFFF0, 32'h2, w);
      repeat (9598) @(posedge HCLK);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl busy on last fill cycle", rd, 32'h1);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl after clear 0", rd, 32'h0);

      $display("[TB] frame writes and reads");
      ahbWrite(16'h0000, 32'h0000_0001, w);
      checkOutput("frame write waits", w, 32'd0);
      ahbWrite(16'h0050, 32'h8000_0000, w);
      ahbWriteThenRead(16'h0190, 32'h1234_5678, rd, w);
      checkOutput("write-then-read data", rd, 32'h1234_5678);
      checkOutput("write-then-read waits", w, 32'd1);
      ahbRead(16'h0050, rd, w);
      checkOutput("read 0x0050 data", rd, 32'h8000_0000);
      checkOutput("read 0x0050 waits", w, 32'd1);
      applyStimulus(1);

      ahbRead(16'h9600, rd, w);
      checkOutput("read beyond frame", rd, 32'd0);
      ahbXfer(1'b1, 16'h0000, 3'b000, 32'hFFFF_FFFF, rd, w);
      ahbXfer(1'b0, 16'h0000, 3'b000, 32'd0, rd, w);
      checkOutput("byte read", rd, 32'd0);
      ahbRead(16'h0000, rd, w);
      checkOutput("word 0 after byte write", rd, 32'h0000_0001);
      applyStimulus(2);

      $display("[TB] clear to 1 with stalled write");
      ahbWrite(16'hFFF0, 32'h3, w);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl during clear 1", rd, 32'h3);
      ahbWrite(16'hFFF0, 32'h2, w);
      checkOutput("ctrl write waits while busy", w, 32'd0);
      ahbWrite(16'h0000, 32'h0000_0000, w);
      checkOutput("stalled write waits", w, 32'd9595);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl after clear 1", rd, 32'h2);
      applyStimulus(3);

      $display("[TB] reset mid-clear");
      ahbWrite(16'hFFF0, 32'h2, w);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl before mid-clear reset", rd, 32'h1);
      repeat (10) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      checkOutput("HREADYOUT after mid-clear reset", {31'd0, HREADYOUT}, 32'd1);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("ctrl after mid-clear reset", rd, 32'h0);
      applyStimulus(4);
      ahbWrite(16'hFFF0, 32'h3, w);
      ahbRead(16'hFFF0, rd, w);
      checkOutput("restart after reset", rd, 32'h3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
